// File: rtl/ram_sp_be_pipe.sv
// Single-port synchronous RAM with separate read and write buses.
// Features: per-byte write enables, read latency of 1 or 2 cycles with an
// rvalid strobe, optional write-response readback, and an optional
// zero-fill clear after reset gated by a ready flag.
module ram_sp_be_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_W         = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
    parameter int READ_LATENCY   = 1,
    parameter int WR_RESP        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cs,
    input  logic                           we,
    input  logic [DATA_WIDTH/BYTE_W-1:0]   be,
    input  logic [ADDR_WIDTH-1:0]          address,
    input  logic [DATA_WIDTH-1:0]          wdata,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           rvalid,
    output logic                           ready
);

    localparam int NB = DATA_WIDTH / BYTE_W;

    // Parameter sanity checks.
    if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_byte_w
        $error("DATA_WIDTH must be a multiple of BYTE_W");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if (RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("RAM_DEPTH exceeds the address space");
    end

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;

    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    logic                    in_range;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   merged;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic                    s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;

    assign ready    = (state_q == ST_RUN);
    assign accept   = cs && ready;
    assign in_range = (32'(address) < 32'(RAM_DEPTH));
    assign rd_word  = in_range ? mem[address] : '0;

    // Clear sequencer next state: walk every address once, then run.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
            if (32'(clr_addr_q) == 32'(RAM_DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // Clear sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Byte-lane merge of write data over the current word.
    always_comb begin
        merged = rd_word;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Memory write port: clear writes take priority over user writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = address;
        mem_wdata = merged;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = '0;
        end else if (accept && we && in_range) begin
            mem_we = 1'b1;
        end
    end

    // Memory array update; contents are never reset directly.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // First pipeline stage: capture read word or write-first response.
    always_comb begin
        s1_valid_d = accept && (!we || (WR_RESP != 0));
        s1_data_d  = s1_data_q;
        if (s1_valid_d) begin
            s1_data_d = we ? (in_range ? merged : '0) : rd_word;
        end
    end

    // First pipeline stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_valid_q, s2_valid_d;
        logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

        // Second stage: load only on a valid beat so rdata holds otherwise.
        always_comb begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
        end

        // Second pipeline stage registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_data_q  <= s2_data_d;
            end
        end

        assign rdata  = s2_data_q;
        assign rvalid = s2_valid_q;
    end else begin : g_lat1
        assign rdata  = s1_data_q;
        assign rvalid = s1_valid_q;
    end

endmodule

// File: tb/tb_ram_sp_be_pipe.sv
// Bench for ram_sp_be_pipe: three configurations share one input bus.
//   A: depth 16, latency 1, write response, clear on reset
//   B: depth 16, latency 2, no write response, clear on reset
//   C: depth 12, latency 1, no write response, no clear
module tb_ram_sp_be_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [3:0]  address = '0;
    logic [31:0] wdata = '0;

    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic        rvalid_a, rvalid_b, rvalid_c;
    logic        ready_a, ready_b, ready_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_sp_be_pipe #(.DATA_WIDTH(32), .BYTE_W(8), .ADDR_WIDTH(4), .RAM_DEPTH(16),
                     .READ_LATENCY(1), .WR_RESP(1), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .be(be), .address(address),
        .wdata(wdata), .rdata(rdata_a), .rvalid(rvalid_a), .ready(ready_a));

    ram_sp_be_pipe #(.DATA_WIDTH(32), .BYTE_W(8), .ADDR_WIDTH(4), .RAM_DEPTH(16),
                     .READ_LATENCY(2), .WR_RESP(0), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .be(be), .address(address),
        .wdata(wdata), .rdata(rdata_b), .rvalid(rvalid_b), .ready(ready_b));

    ram_sp_be_pipe #(.DATA_WIDTH(32), .BYTE_W(8), .ADDR_WIDTH(4), .RAM_DEPTH(12),
                     .READ_LATENCY(1), .WR_RESP(0), .CLEAR_ON_RESET(0)) u_c (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .be(be), .address(address),
        .wdata(wdata), .rdata(rdata_c), .rvalid(rvalid_c), .ready(ready_c));

    // One clock cycle: drive inputs, take the edge, settle 1 time unit after.
    task automatic cyc(input logic c, input logic w, input logic [3:0] b,
                       input logic [3:0] a, input logic [31:0] d);
        cs = c; we = w; be = b; address = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk1("reset_rvalid_a", rvalid_a, 1'b0);
        chk32("reset_rdata_a", rdata_a, 32'h0);
        chk1("reset_ready_a", ready_a, 1'b0);
        chk1("reset_rvalid_b", rvalid_b, 1'b0);
        chk1("reset_ready_b", ready_b, 1'b0);
        chk1("reset_ready_c", ready_c, 1'b1);
        chk32("reset_rdata_c", rdata_c, 32'h0);
    endtask

    // Release reset with cs reads held; ready must rise after exactly 16 edges.
    task automatic test_clear();
        cs = 1'b1; we = 1'b0; be = 4'h0; address = 4'd5; wdata = '0;
        rst = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            cyc(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
            if (i <= 16) begin
                chk1($sformatf("clear_ready_a_%0d", i), ready_a, (i == 16));
                chk1($sformatf("clear_ready_b_%0d", i), ready_b, (i == 16));
                chk1($sformatf("clear_rvalid_a_%0d", i), rvalid_a, 1'b0);
                chk1($sformatf("clear_rvalid_b_%0d", i), rvalid_b, 1'b0);
            end else begin
                chk1("clear_first_rvalid_a", rvalid_a, 1'b1);
                chk32("clear_first_rdata_a", rdata_a, 32'h0);
            end
        end
        cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        chk1("clear_first_rvalid_b", rvalid_b, 1'b1);
        chk32("clear_first_rdata_b", rdata_b, 32'h0);
        idle(2);
    endtask

    task automatic test_byte_en();
        cyc(1'b1, 1'b1, 4'b1111, 4'd3, 32'hAABBCCDD);
        chk1("be_wresp1_v_a", rvalid_a, 1'b1);
        chk32("be_wresp1_d_a", rdata_a, 32'hAABBCCDD);
        chk1("be_wr1_v_b", rvalid_b, 1'b0);
        cyc(1'b1, 1'b1, 4'b0101, 4'd3, 32'h11223344);
        chk1("be_wresp2_v_a", rvalid_a, 1'b1);
        chk32("be_wresp2_d_a", rdata_a, 32'hAA22CC44);
        chk1("be_wr2_v_b", rvalid_b, 1'b0);
        cyc(1'b1, 1'b0, 4'b0000, 4'd3, 32'h0);
        chk1("be_rd_v_a", rvalid_a, 1'b1);
        chk32("be_rd_d_a", rdata_a, 32'hAA22CC44);
        chk1("be_rd_early_v_b", rvalid_b, 1'b0);
        cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        chk1("be_rd_v_b", rvalid_b, 1'b1);
        chk32("be_rd_d_b", rdata_b, 32'hAA22CC44);
        idle(2);
    endtask

    task automatic test_streaming();
        logic        exp_va [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp_da [5] = '{32'd10, 32'd20, 32'd30, 32'd30, 32'd30};
        logic        exp_vb [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_db [5] = '{32'hAA22CC44, 32'd10, 32'd20, 32'd30, 32'd30};
        cyc(1'b1, 1'b1, 4'hF, 4'd0, 32'd10);
        cyc(1'b1, 1'b1, 4'hF, 4'd1, 32'd20);
        cyc(1'b1, 1'b1, 4'hF, 4'd2, 32'd30);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) cyc(1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
            else       cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
            chk1($sformatf("stream_v_a_%0d", i), rvalid_a, exp_va[i]);
            chk32($sformatf("stream_d_a_%0d", i), rdata_a, exp_da[i]);
            chk1($sformatf("stream_v_b_%0d", i), rvalid_b, exp_vb[i]);
            chk32($sformatf("stream_d_b_%0d", i), rdata_b, exp_db[i]);
        end
        idle(2);
    endtask

    task automatic test_wr_resp();
        cyc(1'b1, 1'b1, 4'b0011, 4'd7, 32'h0000FFFF);
        chk1("wresp_v_a", rvalid_a, 1'b1);
        chk32("wresp_d_a", rdata_a, 32'h0000FFFF);
        chk1("wresp_none_b0", rvalid_b, 1'b0);
        cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        chk1("wresp_after_a", rvalid_a, 1'b0);
        chk1("wresp_none_b1", rvalid_b, 1'b0);
        cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        chk1("wresp_none_b2", rvalid_b, 1'b0);
    endtask

    // Latency-2 read in flight must not see a write issued right behind it.
    task automatic test_inflight();
        cyc(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
        cyc(1'b1, 1'b1, 4'hF, 4'd3, 32'h55667788);
        chk1("inflight_v_b", rvalid_b, 1'b1);
        chk32("inflight_d_b", rdata_b, 32'hAA22CC44);
        cyc(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
        chk1("rdafterwr_v_a", rvalid_a, 1'b1);
        chk32("rdafterwr_d_a", rdata_a, 32'h55667788);
        cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        chk1("rdafterwr_v_b", rvalid_b, 1'b1);
        chk32("rdafterwr_d_b", rdata_b, 32'h55667788);
        idle(2);
    endtask

    task automatic test_out_of_range();
        cyc(1'b1, 1'b1, 4'hF, 4'd1, 32'h12345678);
        chk1("oor_wr_v_c", rvalid_c, 1'b0);
        cyc(1'b1, 1'b1, 4'hF, 4'd13, 32'hDEADBEEF);
        chk1("oor_wr13_v_c", rvalid_c, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 4'd1, 32'h0);
        chk1("oor_rd1_v_c", rvalid_c, 1'b1);
        chk32("oor_rd1_d_c", rdata_c, 32'h12345678);
        cyc(1'b1, 1'b0, 4'h0, 4'd13, 32'h0);
        chk1("oor_rd13_v_c", rvalid_c, 1'b1);
        chk32("oor_rd13_d_c", rdata_c, 32'h0);
        cyc(1'b1, 1'b0, 4'h0, 4'd1, 32'h0);
        chk1("oor_rd1b_v_c", rvalid_c, 1'b1);
        chk32("oor_rd1b_d_c", rdata_c, 32'h12345678);
        idle(2);
    endtask

    // Reset with a latency-2 read in flight, then reset again mid-clear.
    task automatic test_reset_inflight();
        cyc(1'b1, 1'b0, 4'h0, 4'd0, 32'h0);
        rst = 1'b1;
        #1;
        chk1("rstfly_v_b", rvalid_b, 1'b0);
        chk32("rstfly_d_b", rdata_b, 32'h0);
        chk1("rstfly_ready_b", ready_b, 1'b0);
        cs = 1'b0;
        @(posedge clk); #1;
        chk1("rstfly_v_b_hold", rvalid_b, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
            chk1($sformatf("rstfly_v_b_%0d", i), rvalid_b, 1'b0);
            chk1($sformatf("rstmid_ready_a_%0d", i), ready_a, 1'b0);
        end
        rst = 1'b1;
        #1;
        chk1("rstmid_ready_a", ready_a, 1'b0);
        chk1("rstmid_rvalid_a", rvalid_a, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
            chk1($sformatf("rstmid_reclear_ready_a_%0d", i), ready_a, (i == 16));
            chk1($sformatf("rstmid_reclear_rvalid_a_%0d", i), rvalid_a, 1'b0);
        end
        idle(3);
    endtask

    // Randomised traffic against a word-level model with a timed response queue.
    typedef struct {
        int          due;
        logic [31:0] d;
    } resp_t;

    task automatic test_random(input int sel, input int n);
        logic [31:0] m [16];
        resp_t       q [$];
        resp_t       r;
        int          lat, depth, k_ready;
        bit          wresp;
        logic [31:0] last, old, mrg, act_d;
        logic        c, w, exp_v, act_v, act_rdy;
        logic [3:0]  b, a;
        logic [31:0] d;

        lat   = (sel == 1) ? 2 : 1;
        wresp = (sel == 0);
        depth = 16;
        for (int i = 0; i < 16; i++) m[i] = '0;
        last = '0;

        rst = 1'b1;
        cs  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        k_ready = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
            act_rdy = (sel == 0) ? ready_a : ready_b;
            if (act_rdy === 1'b1) begin
                k_ready = i;
                break;
            end
        end
        n_cmp++;
        if (k_ready != 16) begin
            n_err++;
            $display("FAIL rand%0d_ready_cycles: got %0d expected 16", sel, k_ready);
        end

        for (int k = 0; k < n; k++) begin
            c = (k < n - 3) ? ($urandom_range(0, 9) < 8) : 1'b0;
            w = $urandom_range(0, 1);
            b = 4'($urandom);
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            if (c) begin
                old = (a < depth) ? m[a] : 32'h0;
                if (w) begin
                    mrg = old;
                    for (int l = 0; l < 4; l++) if (b[l]) mrg[l*8 +: 8] = d[l*8 +: 8];
                    if (a < depth) m[a] = mrg;
                    if (wresp) q.push_back('{due: k + lat - 1, d: (a < depth) ? mrg : 32'h0});
                end else begin
                    q.push_back('{due: k + lat - 1, d: old});
                end
            end
            cyc(c, w, b, a, d);
            exp_v = 1'b0;
            if (q.size() > 0 && q[0].due == k) begin
                r     = q.pop_front();
                exp_v = 1'b1;
                last  = r.d;
            end
            act_v = (sel == 0) ? rvalid_a : rvalid_b;
            act_d = (sel == 0) ? rdata_a : rdata_b;
            n_cmp++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL rand%0d_rvalid cycle %0d: got %b expected %b", sel, k, act_v, exp_v);
            end
            n_cmp++;
            if (act_d !== last) begin
                n_err++;
                $display("FAIL rand%0d_rdata cycle %0d: got %h expected %h", sel, k, act_d, last);
            end
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL rand%0d_drain: got %0d pending expected 0", sel, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_byte_en();
        test_streaming();
        test_wr_resp();
        test_inflight();
        test_out_of_range();
        test_reset_inflight();
        test_random(0, 400);
        test_random(1, 400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_sp_be_pipe.md
Name: ram_sp_be_pipe

Overview:
- Parametrised successor to the team's single-port synchronous RAM.
- Replaces the bidirectional data bus with separate write and read buses.
- Adds per-byte write enables, configurable read latency (1 or 2) with a read-valid strobe, an optional write-response readback, and an optional post-reset clear sequence with a ready flag.
- Used as the generic local buffer or register-file macro behind datapath blocks.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, bits per byte-enable lane.
- ADDR_WIDTH, 8, address width.
- RAM_DEPTH, 1 << ADDR_WIDTH, number of words; must be <= 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from accepted read to rvalid; legal values 1 or 2.
- WR_RESP, 0, 1 = an accepted write also returns the merged post-write word on rdata with rvalid.
- CLEAR_ON_RESET, 1, 1 = memory is zero-filled after reset before accesses are accepted.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- cs  input  1  chip select / request valid
- we  input  1  1 = write, 0 = read
- be  input  DATA_WIDTH/BYTE_W  byte-lane write enables, ignored on reads
- address  input  ADDR_WIDTH  word address
- wdata  input  DATA_WIDTH  write data
- rdata  output  DATA_WIDTH  read / write-response data
- rvalid  output  1  one-cycle strobe, rdata valid
- ready  output  1  1 = block accepts requests

Behaviour:
Reset (rst asserted, asynchronous):
- rdata = 0, rvalid = 0.
- Read pipeline valid bits cleared.
- ready = 0 if CLEAR_ON_RESET = 1, else ready = 1.
- Memory contents are not reset directly.

Clear state machine (CLEAR_ON_RESET = 1), states CLEAR and RUN:
- Reset forces CLEAR with clr_addr = 0.
- In CLEAR: each cycle writes 0 to mem[clr_addr] and increments clr_addr.
- After writing RAM_DEPTH-1, moves to RUN next cycle and ready rises. Clear takes exactly RAM_DEPTH cycles after reset deassertion.
- While ready = 0: cs is ignored, no memory update, no rvalid.
- Reset asserted mid-clear restarts the clear from address 0.
- With CLEAR_ON_RESET = 0: the machine sits in RUN permanently.

Accept rule:
- A request is accepted on a rising edge when cs && ready.
- No back-pressure; one request per cycle.

Write (accepted, we = 1):
- For each lane i with be[i] = 1, mem[address] lane i <= wdata lane i. Other lanes are unchanged.
- be = all zero is a legal no-op, but still counts as accepted for WR_RESP.

Read (accepted, we = 0):
- mem[address] is captured at the accept edge.
- READ_LATENCY = 1: rdata and rvalid update at the accept edge, so they are visible in the next cycle.
- READ_LATENCY = 2: one additional output register stage; rvalid appears one cycle later.
- Back-to-back reads give back-to-back rvalid pulses, in order.

Write response (WR_RESP = 1):
- An accepted write enters the same pipeline as a read.
- The returned value is the merged word after the write (write-first).
- WR_RESP = 0: writes never raise rvalid.

rdata hold:
- rdata holds its last value when rvalid = 0.
- rdata is never driven to X or Z after reset.

Out-of-range address (address >= RAM_DEPTH):
- Writes are dropped.
- Reads return 0 with normal rvalid timing.

Ordering:
- A read accepted in the cycle after a write to the same address returns the new data.
- With READ_LATENCY = 2, a write to an address whose read is already in flight does not alter the in-flight data.

Elaboration checks:
- Elaboration error if DATA_WIDTH % BYTE_W != 0.
- Elaboration error if READ_LATENCY is not 1 or 2.
- Elaboration error if RAM_DEPTH > 2**ADDR_WIDTH.

Test Plan:
- Clear sequence: CLEAR_ON_RESET = 1, RAM_DEPTH = 16; release rst, assert cs reads throughout -> ready rises exactly 16 cycles after rst low, no rvalid before ready, first read of address 5 returns 0x00000000.
- Byte enables: write 0xAABBCCDD to address 3 with be = 4'b1111, then write 0x11223344 with be = 4'b0101, then read address 3 -> rdata = 0xAA22CC44.
- Latency and streaming:
  - READ_LATENCY = 1: reads of addresses 0, 1, 2 on consecutive cycles (mem = 10, 20, 30) -> rvalid high 3 consecutive cycles starting 1 cycle after the first accept, data 10, 20, 30.
  - READ_LATENCY = 2: same stimulus -> rvalid starts 2 cycles after the first accept, same data.
- Write response: WR_RESP = 1, mem[7] = 0x00000000; write 0x0000FFFF to address 7 with be = 4'b0011 -> rvalid pulse with rdata = 0x0000FFFF. Same write with WR_RESP = 0 -> no rvalid.
- Reset mid-operation:
  - Assert rst at clear cycle 8 of 16 -> ready = 0 and rvalid = 0 immediately; after release, ready rises 16 cycles later.
  - Assert rst with a read in flight at READ_LATENCY = 2 -> that read's rvalid never appears.
- Out of range: RAM_DEPTH = 12, ADDR_WIDTH = 4; write 0xDEADBEEF to address 13, then read address 13 -> rdata = 0 with rvalid. Read address 1 -> its contents are unchanged.
